// File: rtl/spi_reg_bank_pkg.sv
// ---------------------------------------------------------------------------
// spi_reg_bank_pkg
// Shared definitions for the SPI-programmed PWM register bank: frame geometry,
// register address map, reset values and the frame classification helper.
// ---------------------------------------------------------------------------
package spi_reg_bank_pkg;

  // Frame geometry: [15] R/W, [14:8] address, [7:0] data, MSB first.
  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = 5;
  localparam int DIV_W      = 4;

  // Bit counter values of interest: a complete frame, and the overflow mark.
  localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
  localparam logic [CNT_W-1:0] CNT_SAT  = 5'd17;

  // Register address map.
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT     = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM     = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_CHAN_3_0   = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_CHAN_7_4   = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_DUTY_1     = 7'h04;
  localparam logic [ADDR_W-1:0] ADDR_DUTY_2     = 7'h05;
  localparam logic [ADDR_W-1:0] ADDR_DUTY_3     = 7'h06;
  localparam logic [ADDR_W-1:0] ADDR_DUTY_4     = 7'h07;
  localparam logic [ADDR_W-1:0] ADDR_FREQ_DIV   = 7'h08;

  // Register reset values.
  localparam logic [DATA_W-1:0] RST_EN_OUT   = 8'h00;
  localparam logic [DATA_W-1:0] RST_EN_PWM   = 8'h00;
  localparam logic [DATA_W-1:0] RST_CHAN_3_0 = 8'h00;
  localparam logic [DATA_W-1:0] RST_CHAN_7_4 = 8'h00;
  localparam logic [DATA_W-1:0] RST_DUTY     = 8'h00;
  localparam logic [DIV_W-1:0]  RST_FREQ_DIV = 4'h0;

  // Outcome of a frame at nCS rise.
  typedef enum logic [1:0] {
    FRAME_WRITE  = 2'd0,
    FRAME_READ   = 2'd1,
    FRAME_REJECT = 2'd2
  } frame_kind_e;

  // Decide what a finished frame does. Reads of full length are dropped
  // silently; wrong length or out-of-range writes are rejected.
  function automatic frame_kind_e classify_frame(
    input logic [CNT_W-1:0]  bit_cnt,
    input logic              rw,
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] max_addr
  );
    frame_kind_e kind;
    if (bit_cnt != CNT_FULL) begin
      kind = FRAME_REJECT;
    end else if (!rw) begin
      kind = FRAME_READ;
    end else if (addr > max_addr) begin
      kind = FRAME_REJECT;
    end else begin
      kind = FRAME_WRITE;
    end
    return kind;
  endfunction

endpackage

// File: rtl/spi_reg_bank_sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// N-flop synchroniser for an asynchronous pin, followed by one history flop
// that yields single-cycle rise/fall pulses in the clk domain.
//   clk, rst_n : clock, async active-low reset
//   d          : asynchronous input pin
//   q          : synchronised level
//   rise, fall : one-cycle pulses on synchronised edges
// ---------------------------------------------------------------------------
module sync_edge #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [N-1:0] chain_q;
  logic [N-1:0] chain_d;
  logic         prev_q;
  logic         prev_d;

  // Next state of the synchroniser chain and the edge-history flop.
  always_comb begin
    chain_d = {chain_q[N-2:0], d};
    prev_d  = chain_q[N-1];
  end

  // Synchroniser and history flops; reset to the pin's idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {N{RST_VAL}};
      prev_q  <= RST_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign q    = chain_q[N-1];
  assign rise =  chain_q[N-1] & ~prev_q;
  assign fall = ~chain_q[N-1] &  prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// ---------------------------------------------------------------------------
// spi_reg_bank
// Write-only SPI mode-0 target holding the PWM control register file.
// 16-bit frames (R/W, 7-bit address, 8-bit data, MSB first) are shifted in on
// synchronised SCLK rises and committed on the synchronised nCS rise.
//   clk, rst_n                : system clock, async active-low reset
//   sclk, copi, ncs           : asynchronous SPI pins
//   reg_*                     : configuration registers (addresses 0x00..0x08)
//   wr_strobe                 : one-cycle pulse when a register is written
//   txn_error                 : one-cycle pulse when a frame is rejected
// ---------------------------------------------------------------------------
module spi_reg_bank
  import spi_reg_bank_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              copi,
  input  logic              ncs,
  output logic [DATA_W-1:0] reg_en_out,
  output logic [DATA_W-1:0] reg_en_pwm_out,
  output logic [DATA_W-1:0] reg_out_3_0_pwm_chanel,
  output logic [DATA_W-1:0] reg_out_7_4_pwm_chanel,
  output logic [DATA_W-1:0] reg_pwm_gen_1_duty_cycle,
  output logic [DATA_W-1:0] reg_pwm_gen_2_duty_cycle,
  output logic [DATA_W-1:0] reg_pwm_gen_3_duty_cycle,
  output logic [DATA_W-1:0] reg_pwm_gen_4_duty_cycle,
  output logic [DIV_W-1:0]  reg_pwm_frequency_divider,
  output logic              wr_strobe,
  output logic              txn_error
);

  localparam logic [ADDR_W-1:0] MAX_ADDR_L = ADDR_W'(MAX_ADDR);

  // Synchronised pins.
  logic sclk_rise, sclk_sync_unused, sclk_fall_unused;
  logic ncs_sync, ncs_rise, ncs_fall;
  logic copi_sync, copi_rise_unused, copi_fall_unused;

  sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk),
    .q(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  // nCS idles high, so its synchroniser resets to 1.
  sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d(ncs),
    .q(ncs_sync), .rise(ncs_rise), .fall(ncs_fall)
  );

  sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d(copi),
    .q(copi_sync), .rise(copi_rise_unused), .fall(copi_fall_unused)
  );

  // Frame state.
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Register file and pulses.
  logic [DATA_W-1:0] en_out_q,   en_out_d;
  logic [DATA_W-1:0] en_pwm_q,   en_pwm_d;
  logic [DATA_W-1:0] chan_30_q,  chan_30_d;
  logic [DATA_W-1:0] chan_74_q,  chan_74_d;
  logic [DATA_W-1:0] duty_1_q,   duty_1_d;
  logic [DATA_W-1:0] duty_2_q,   duty_2_d;
  logic [DATA_W-1:0] duty_3_q,   duty_3_d;
  logic [DATA_W-1:0] duty_4_q,   duty_4_d;
  logic [DIV_W-1:0]  freq_div_q, freq_div_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic              txn_error_q, txn_error_d;

  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;
  frame_kind_e       frame_kind;

  assign frame_addr = shift_q[FRAME_BITS-2 -: ADDR_W];
  assign frame_data = shift_q[DATA_W-1:0];
  assign frame_kind = classify_frame(cnt_q, shift_q[FRAME_BITS-1], frame_addr, MAX_ADDR_L);

  // Frame capture and commit. The nCS rise takes priority, so an SCLK rise
  // landing in the same cycle is dropped and the commit sees the old shift.
  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    en_out_d    = en_out_q;
    en_pwm_d    = en_pwm_q;
    chan_30_d   = chan_30_q;
    chan_74_d   = chan_74_q;
    duty_1_d    = duty_1_q;
    duty_2_d    = duty_2_q;
    duty_3_d    = duty_3_q;
    duty_4_d    = duty_4_q;
    freq_div_d  = freq_div_q;
    wr_strobe_d = 1'b0;
    txn_error_d = 1'b0;

    if (ncs_rise) begin
      case (frame_kind)
        FRAME_WRITE: begin
          wr_strobe_d = 1'b1;
          case (frame_addr)
            ADDR_EN_OUT:   en_out_d   = frame_data;
            ADDR_EN_PWM:   en_pwm_d   = frame_data;
            ADDR_CHAN_3_0: chan_30_d  = frame_data;
            ADDR_CHAN_7_4: chan_74_d  = frame_data;
            ADDR_DUTY_1:   duty_1_d   = frame_data;
            ADDR_DUTY_2:   duty_2_d   = frame_data;
            ADDR_DUTY_3:   duty_3_d   = frame_data;
            ADDR_DUTY_4:   duty_4_d   = frame_data;
            ADDR_FREQ_DIV: freq_div_d = frame_data[DIV_W-1:0];
            default: begin
            end
          endcase
        end
        FRAME_READ: begin
        end
        FRAME_REJECT: txn_error_d = 1'b1;
        default:      txn_error_d = 1'b1;
      endcase
    end else if (ncs_fall) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (sclk_rise && !ncs_sync) begin
      shift_d = {shift_q[FRAME_BITS-2:0], copi_sync};
      // Saturate so arbitrarily long frames still read as overflow.
      if (cnt_q >= CNT_SAT) begin
        cnt_d = CNT_SAT;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      en_out_q    <= RST_EN_OUT;
      en_pwm_q    <= RST_EN_PWM;
      chan_30_q   <= RST_CHAN_3_0;
      chan_74_q   <= RST_CHAN_7_4;
      duty_1_q    <= RST_DUTY;
      duty_2_q    <= RST_DUTY;
      duty_3_q    <= RST_DUTY;
      duty_4_q    <= RST_DUTY;
      freq_div_q  <= RST_FREQ_DIV;
      wr_strobe_q <= 1'b0;
      txn_error_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      en_out_q    <= en_out_d;
      en_pwm_q    <= en_pwm_d;
      chan_30_q   <= chan_30_d;
      chan_74_q   <= chan_74_d;
      duty_1_q    <= duty_1_d;
      duty_2_q    <= duty_2_d;
      duty_3_q    <= duty_3_d;
      duty_4_q    <= duty_4_d;
      freq_div_q  <= freq_div_d;
      wr_strobe_q <= wr_strobe_d;
      txn_error_q <= txn_error_d;
    end
  end

  assign reg_en_out                = en_out_q;
  assign reg_en_pwm_out            = en_pwm_q;
  assign reg_out_3_0_pwm_chanel    = chan_30_q;
  assign reg_out_7_4_pwm_chanel    = chan_74_q;
  assign reg_pwm_gen_1_duty_cycle  = duty_1_q;
  assign reg_pwm_gen_2_duty_cycle  = duty_2_q;
  assign reg_pwm_gen_3_duty_cycle  = duty_3_q;
  assign reg_pwm_gen_4_duty_cycle  = duty_4_q;
  assign reg_pwm_frequency_divider = freq_div_q;
  assign wr_strobe                 = wr_strobe_q;
  assign txn_error                 = txn_error_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_bank
// Drives SPI frames at SCLK = clk/8 and checks the register file, the
// wr_strobe / txn_error pulse counts and the commit latency against a
// frame-level model of the register bank.
// ---------------------------------------------------------------------------
module tb_spi_reg_bank;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk  = 1'b0;
  logic       copi  = 1'b0;
  logic       ncs   = 1'b1;
  logic [7:0] r_en_out, r_en_pwm, r_ch30, r_ch74, r_d1, r_d2, r_d3, r_d4;
  logic [3:0] r_div;
  logic       wr_strobe, txn_error;

  spi_reg_bank dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .reg_en_out(r_en_out), .reg_en_pwm_out(r_en_pwm),
    .reg_out_3_0_pwm_chanel(r_ch30), .reg_out_7_4_pwm_chanel(r_ch74),
    .reg_pwm_gen_1_duty_cycle(r_d1), .reg_pwm_gen_2_duty_cycle(r_d2),
    .reg_pwm_gen_3_duty_cycle(r_d3), .reg_pwm_gen_4_duty_cycle(r_d4),
    .reg_pwm_frequency_divider(r_div),
    .wr_strobe(wr_strobe), .txn_error(txn_error)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nfail = 0;
  int n_wr = 0;
  int n_err = 0;
  logic [7:0] mreg [0:8];

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    int          gap;
    int          exp_wr;
    int          exp_err;
  } vec_t;

  vec_t tbl [0:5];

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) n_wr <= n_wr + 1;
    if (txn_error === 1'b1) n_err <= n_err + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] dut_reg(input int i);
    case (i)
      0: return r_en_out;
      1: return r_en_pwm;
      2: return r_ch30;
      3: return r_ch74;
      4: return r_d1;
      5: return r_d2;
      6: return r_d3;
      7: return r_d4;
      8: return {4'h0, r_div};
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("%s reg%0d", tag, i), {24'h0, dut_reg(i)}, {24'h0, mreg[i]});
    end
  endtask

  // Frame-level reference: only a full 16-bit write to 0..8 changes state.
  task automatic model_frame(input logic [31:0] bits, input int n, output int ewr, output int eerr);
    logic [15:0] f;
    int a;
    f = bits[15:0];
    a = int'(f[14:8]);
    ewr = 0;
    eerr = 0;
    if (n != 16) begin
      eerr = 1;
    end else if (f[15] == 1'b0) begin
      ewr = 0;
    end else if (a > 8) begin
      eerr = 1;
    end else begin
      ewr = 1;
      mreg[a] = (a == 8) ? {4'h0, f[3:0]} : f[7:0];
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    sclk = 1'b0;
    ncs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = bits[i];
      sclk = 1'b0;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    sclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Raise nCS and record at which rising clk edge each pulse first shows.
  task automatic end_frame(input int gap, output int lat_wr, output int lat_err);
    lat_wr = 0;
    lat_err = 0;
    ncs = 1'b1;
    for (int k = 1; k <= gap; k++) begin
      @(posedge clk);
      #1;
      if (wr_strobe === 1'b1 && lat_wr == 0) lat_wr = k;
      if (txn_error === 1'b1 && lat_err == 0) lat_err = k;
    end
    @(negedge clk);
  endtask

  // exp_wr / exp_err < 0 means take the expectation from the model.
  task automatic run_frame(input string tag, input logic [31:0] bits, input int n,
                           input int gap, input int exp_wr, input int exp_err);
    int w0, e0, lw, le, mw, me, ew, ee;
    model_frame(bits, n, mw, me);
    ew = (exp_wr < 0) ? mw : exp_wr;
    ee = (exp_err < 0) ? me : exp_err;
    w0 = n_wr;
    e0 = n_err;
    start_frame();
    shift_bits(bits, n);
    end_frame(gap, lw, le);
    check({tag, " wr_strobe count"}, n_wr - w0, ew);
    check({tag, " txn_error count"}, n_err - e0, ee);
    if (ew == 1) check({tag, " wr_strobe latency"}, lw, 3);
    if (ee == 1) check({tag, " txn_error latency"}, le, 3);
    check_regs(tag);
  endtask

  initial begin
    int w0, e0, lw, le, r, n;
    logic [15:0] f;
    logic [31:0] bits;

    tbl[0] = '{32'h0000_8480, 16, 8, 1, 0};
    tbl[1] = '{32'h0000_88F5, 16, 8, 1, 0};
    tbl[2] = '{32'h0000_0811, 16, 8, 0, 0};
    tbl[3] = '{32'h0000_8955, 16, 8, 0, 1};
    tbl[4] = '{32'h0000_40FF, 15, 8, 0, 1};
    tbl[5] = '{32'h0001_03FE, 17, 8, 0, 1};

    for (int i = 0; i < 9; i++) mreg[i] = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check_regs("reset");
    check("reset wr_strobe", {31'h0, wr_strobe}, 32'h0);
    check("reset txn_error", {31'h0, txn_error}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Directed table: write, divider write, read, bad address, short, long.
    for (int i = 0; i < 6; i++) begin
      run_frame($sformatf("tbl%0d", i), tbl[i].bits, tbl[i].nbits, tbl[i].gap,
                tbl[i].exp_wr, tbl[i].exp_err);
    end

    // Back-to-back writes with the minimum nCS-high gap.
    w0 = n_wr;
    for (int a = 0; a < 9; a++) begin
      bits = {16'h0, 1'b1, 7'(a), 8'(17 * (a + 1))};
      run_frame($sformatf("b2b%0d", a), bits, 16, 4, 1, 0);
    end
    check("b2b total wr_strobe", n_wr - w0, 9);

    // Reset in the middle of a frame, released with nCS still low.
    w0 = n_wr;
    e0 = n_err;
    start_frame();
    shift_bits(32'h80, 8);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 9; i++) mreg[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("midrst reg_en_out in reset", {24'h0, r_en_out}, 32'h0);
    check("midrst divider in reset", {28'h0, r_div}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    shift_bits(32'hAA, 8);
    end_frame(8, lw, le);
    check("midrst wr_strobe count", n_wr - w0, 0);
    check("midrst txn_error count", n_err - e0, 1);
    check("midrst txn_error latency", le, 3);
    check_regs("midrst");

    // Randomised frames against the model.
    for (int t = 0; t < 30; t++) begin
      f = {($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 7'($urandom_range(0, 11)), 8'($urandom)};
      r = $urandom_range(0, 5);
      if (r == 0) begin
        n = 15;
        bits = {17'h0, f[15:1]};
      end else if (r == 1) begin
        n = 17;
        bits = {15'h0, f, 1'($urandom)};
      end else begin
        n = 16;
        bits = {16'h0, f};
      end
      run_frame($sformatf("rnd%0d f=%04h n=%0d", t, f, n), bits, n,
                $urandom_range(4, 8), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
